// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the multiplexed 7-segment controller.
//   - character-code constants (5-bit codes written by the host)
//   - write-path FSM state type
//   - seg7_decode(): 5-bit code -> active-high segment pattern {g,f,e,d,c,b,a}
package seg7_pkg;

  localparam int unsigned CHAR_W = 5;

  localparam logic [CHAR_W-1:0] CH_BLANK = 5'h10;
  localparam logic [CHAR_W-1:0] CH_DASH  = 5'h11;
  localparam logic [CHAR_W-1:0] CH_P     = 5'h12;
  localparam logic [CHAR_W-1:0] CH_N     = 5'h13;
  localparam logic [CHAR_W-1:0] CH_U     = 5'h14;
  localparam logic [CHAR_W-1:0] CH_T     = 5'h15;
  localparam logic [CHAR_W-1:0] CH_R     = 5'h16;
  localparam logic [CHAR_W-1:0] CH_L     = 5'h17;
  localparam logic [CHAR_W-1:0] CH_H     = 5'h18;

  // Frame write handshake: Idle accepts, Pending holds the shadow frame until the
  // scan frame ends, Swap copies shadow into the active buffer for one cycle.
  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StSwap
  } wr_state_e;

  // Active-high pattern, bit order {g,f,e,d,c,b,a}. Unused codes decode to blank.
  function automatic logic [6:0] seg7_decode(input logic [CHAR_W-1:0] code);
    logic [6:0] seg;
    case (code)
      5'h00:   seg = 7'h3F;
      5'h01:   seg = 7'h06;
      5'h02:   seg = 7'h5B;
      5'h03:   seg = 7'h4F;
      5'h04:   seg = 7'h66;
      5'h05:   seg = 7'h6D;
      5'h06:   seg = 7'h7D;
      5'h07:   seg = 7'h07;
      5'h08:   seg = 7'h7F;
      5'h09:   seg = 7'h6F;
      5'h0A:   seg = 7'h77;
      5'h0B:   seg = 7'h7C;
      5'h0C:   seg = 7'h39;
      5'h0D:   seg = 7'h5E;
      5'h0E:   seg = 7'h79;
      5'h0F:   seg = 7'h71;
      CH_DASH: seg = 7'h40;
      CH_P:    seg = 7'h73;
      CH_N:    seg = 7'h54;
      CH_U:    seg = 7'h3E;
      CH_T:    seg = 7'h78;
      CH_R:    seg = 7'h50;
      CH_L:    seg = 7'h38;
      CH_H:    seg = 7'h76;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_char_rom.sv
// seg7_char_rom: combinational character ROM.
// Ports:
//   i_code  5-bit character code
//   o_seg   active-high segment pattern {g,f,e,d,c,b,a}; polarity is applied by the caller
module seg7_char_rom
  import seg7_pkg::*;
(
  input  logic [CHAR_W-1:0] i_code,
  output logic [6:0]        o_seg
);

  always_comb begin
    o_seg = seg7_decode(i_code);
  end

endmodule

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: N-digit multiplexed 7-segment display controller.
//
// The host writes a whole frame (char codes, decimal points, blink mask) through a
// valid/ready handshake into a shadow buffer. The shadow is copied into the active
// buffer only right after the last slot of the last digit, so a frame is never torn.
// Each digit slot starts with a blanking gap (all anodes off) to suppress ghosting.
//
// Optional build macro:
//   SEG7_DIMMING_EN  adds i_bright; the anode is gated by a 4-bit PWM inside the lit
//                    part of each slot. i_bright is sampled once per frame.
//
// Ports:
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_wr_valid    frame write request
//   o_wr_ready    shadow buffer free (write accepted on valid & ready)
//   i_wr_chars    5-bit char code per digit, digit 0 (rightmost) in [4:0]
//   i_wr_dp       decimal point per digit
//   i_wr_blink    blink enable per digit
//   o_anode       digit enables, one active at a time (polarity per ACTIVE_LOW)
//   o_seg         segments {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
//   o_dp          decimal point (polarity per ACTIVE_LOW)
//   o_frame_done  one-cycle pulse aligned with the last output cycle of the last digit
//   i_bright      brightness 0..15 (SEG7_DIMMING_EN only)
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned SCAN_HZ    = 1000,
  parameter int unsigned BLANK_CYC  = 64,
  parameter int unsigned BLINK_HZ   = 2,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_valid,
  output logic                       o_wr_ready,
  input  logic [CHAR_W*N_DIGITS-1:0] i_wr_chars,
  input  logic [N_DIGITS-1:0]        i_wr_dp,
  input  logic [N_DIGITS-1:0]        i_wr_blink,
  output logic [N_DIGITS-1:0]        o_anode,
  output logic [6:0]                 o_seg,
  output logic                       o_dp,
  output logic                       o_frame_done
`ifdef SEG7_DIMMING_EN
  ,
  input  logic [3:0]                 i_bright
`endif
);

  localparam int unsigned SLOT_CYC   = CLK_HZ / (SCAN_HZ * N_DIGITS);
  localparam int unsigned SLOT_W     = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int unsigned DIG_W      = $clog2(N_DIGITS);
  localparam int unsigned BLINK_CYC  = CLK_HZ / BLINK_HZ;
  localparam int unsigned BLINK_W    = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam int unsigned BLINK_HALF = BLINK_CYC / 2;
  localparam int unsigned CHARS_W    = CHAR_W * N_DIGITS;

  // Inactive pin levels; XOR-ing an active-high value with these applies polarity.
  localparam logic [N_DIGITS-1:0] ANODE_OFF = {N_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]          SEG_OFF   = {7{ACTIVE_LOW}};
  localparam logic                DP_OFF    = ACTIVE_LOW;

  // ---------------------------------------------------------------------------
  // Scan and blink counters
  // ---------------------------------------------------------------------------
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [DIG_W-1:0]   digit_q, digit_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               slot_wrap, digit_wrap, frame_end;
  logic               lit, blink_off;

  always_comb begin
    slot_wrap  = (slot_q == SLOT_W'(SLOT_CYC - 1));
    digit_wrap = (digit_q == DIG_W'(N_DIGITS - 1));
    frame_end  = slot_wrap && digit_wrap;

    slot_d  = slot_wrap ? '0 : slot_q + 1'b1;
    digit_d = digit_q;
    if (slot_wrap) begin
      digit_d = digit_wrap ? '0 : digit_q + 1'b1;
    end

    blink_d   = (blink_q == BLINK_W'(BLINK_CYC - 1)) ? '0 : blink_q + 1'b1;
    blink_off = (blink_q >= BLINK_W'(BLINK_HALF));

    // Anti-ghosting gap at the start of every slot.
    lit = (slot_q >= SLOT_W'(BLANK_CYC));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_q  <= '0;
      digit_q <= '0;
      blink_q <= '0;
    end else begin
      slot_q  <= slot_d;
      digit_q <= digit_d;
      blink_q <= blink_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM and double buffer
  // ---------------------------------------------------------------------------
  wr_state_e state_q, state_d;
  logic      wr_accept, swap;

  logic [CHARS_W-1:0]  shadow_chars_q, active_chars_q;
  logic [N_DIGITS-1:0] shadow_dp_q, active_dp_q;
  logic [N_DIGITS-1:0] shadow_blink_q, active_blink_q;

  always_comb begin
    state_d    = state_q;
    o_wr_ready = 1'b0;
    wr_accept  = 1'b0;
    swap       = 1'b0;
    unique case (state_q)
      StIdle: begin
        o_wr_ready = 1'b1;
        // A frame end in this same cycle is deliberately ignored: the capture
        // waits for the next frame end so the new frame is shown whole.
        if (i_wr_valid) begin
          wr_accept = 1'b1;
          state_d   = StPending;
        end
      end
      StPending: begin
        if (frame_end) begin
          state_d = StSwap;
        end
      end
      StSwap: begin
        swap    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_chars_q <= {N_DIGITS{CH_BLANK}};
      shadow_dp_q    <= '0;
      shadow_blink_q <= '0;
      active_chars_q <= {N_DIGITS{CH_BLANK}};
      active_dp_q    <= '0;
      active_blink_q <= '0;
    end else begin
      if (wr_accept) begin
        shadow_chars_q <= i_wr_chars;
        shadow_dp_q    <= i_wr_dp;
        shadow_blink_q <= i_wr_blink;
      end
      if (swap) begin
        active_chars_q <= shadow_chars_q;
        active_dp_q    <= shadow_dp_q;
        active_blink_q <= shadow_blink_q;
      end
    end
  end

  // During the swap cycle the counters already sit on slot 0 of digit 0, so the
  // shadow is displayed directly; the first output of a frame is never stale even
  // with no blanking gap.
  logic [CHARS_W-1:0]  disp_chars;
  logic [N_DIGITS-1:0] disp_dp, disp_blink;

  always_comb begin
    disp_chars = swap ? shadow_chars_q : active_chars_q;
    disp_dp    = swap ? shadow_dp_q    : active_dp_q;
    disp_blink = swap ? shadow_blink_q : active_blink_q;
  end

  // ---------------------------------------------------------------------------
  // Current-digit selection
  // ---------------------------------------------------------------------------
  logic [CHAR_W-1:0]   cur_code, rom_code;
  logic                cur_dp, cur_blink, hide, dp_on;
  logic [N_DIGITS-1:0] anode_sel;
  logic [6:0]          rom_seg;

  always_comb begin
    cur_code  = CH_BLANK;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    anode_sel = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (digit_q == DIG_W'(i)) begin
        cur_code     = disp_chars[i*CHAR_W +: CHAR_W];
        cur_dp       = disp_dp[i];
        cur_blink    = disp_blink[i];
        anode_sel[i] = 1'b1;
      end
    end
    hide     = cur_blink && blink_off;
    rom_code = hide ? CH_BLANK : cur_code;
    dp_on    = cur_dp && !hide;
  end

  seg7_char_rom u_char_rom (
    .i_code (rom_code),
    .o_seg  (rom_seg)
  );

  // ---------------------------------------------------------------------------
  // Brightness gating
  // ---------------------------------------------------------------------------
  logic pwm_on;

`ifdef SEG7_DIMMING_EN
  logic [3:0] pwm_q;
  logic [3:0] bright_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pwm_q    <= '0;
      bright_q <= 4'hF;
    end else begin
      pwm_q <= pwm_q + 4'd1;
      // Sampled only at frame end so brightness never changes mid-frame.
      if (frame_end) begin
        bright_q <= i_bright;
      end
    end
  end

  always_comb begin
    pwm_on = (pwm_q < bright_q);
  end
`else
  always_comb begin
    pwm_on = 1'b1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Registered pin drivers
  // ---------------------------------------------------------------------------
  logic [N_DIGITS-1:0] anode_ah;
  logic [6:0]          seg_ah;
  logic                dp_ah;

  logic [N_DIGITS-1:0] anode_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic                frame_done_q;

  always_comb begin
    anode_ah = (lit && pwm_on) ? anode_sel : '0;
    seg_ah   = lit ? rom_seg : 7'h00;
    dp_ah    = lit && dp_on;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      anode_q      <= ANODE_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      anode_q      <= anode_ah ^ ANODE_OFF;
      seg_q        <= seg_ah ^ SEG_OFF;
      dp_q         <= dp_ah ^ DP_OFF;
      // Registered alongside the pins so the pulse marks the last visible cycle.
      frame_done_q <= frame_end;
    end
  end

  assign o_anode      = anode_q;
  assign o_seg        = seg_q;
  assign o_dp         = dp_q;
  assign o_frame_done = frame_done_q;

endmodule
